chan_sel_cmp_pipe: RTL
======================

// Module: chan_sel_cmp_pipe
// PURPOSE
//  Parametrised successor of the team's single-shot 4-way select/threshold comparator.
//  Selects one of NCH W-bit channels, then compares it against a programmable threshold.
//  Four compare modes are supported, with a carry-in tie-break on equality.
//  Results flow through a 2-stage elastic valid/ready pipeline.
//  A saturating hit counter and a select-error flag are maintained.
//  Sits between the channel-select front end and the downstream alarm/aggregation logic.
// PARAMETERS
//  NCH    4  number of input channels (>=2; need not be a power of 2)
//  W      8  channel data / threshold width in bits
//  CNT_W  8  hit counter width in bits
//  SW     $clog2(NCH)  select width (localparam, derived)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       input transaction valid
//  in_ready   out  1       pipeline can accept input this cycle
//  in_data    in   NCH*W   channel c occupies bits [c*W +: W]
//  in_sel     in   SW      channel index
//  in_thr     in   W       unsigned threshold
//  in_cin     in   1       tie-break bit, used when value == threshold
//  in_mode    in   2       00 GE/GT, 01 LE/LT, 10 EQ, 11 NE
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_hit    out  1       compare result
//  out_idx    out  SW      channel index that produced the result
//  out_err    out  1       in_sel was >= NCH
//  hit_cnt    out  CNT_W   count of accepted results with out_hit=1
//  cnt_sat    out  1       hit_cnt is at its maximum value (2^CNT_W-1)
//  cnt_clr    in   1       synchronous clear of hit_cnt
// BEHAVIOUR
//  Reset: clears s1_v, s2_v, out_hit, out_idx, out_err, hit_cnt and cnt_sat to 0.
//   - in_ready is 1 in the first cycle after reset.
//   - Reset mid-operation drops all in-flight transactions; nothing is emitted afterwards.
//  Stage S1 captures on an input handshake (in_valid & in_ready):
//   - selected value, in_thr, in_cin, in_mode, in_sel
//   - err = (in_sel >= NCH); when err, the captured value is 0
//  Stage S2 registers the compare result (eq = val==thr; all compares unsigned):
//   - mode 00: hit = (val > thr) | (eq & cin)
//   - mode 01: hit = (val < thr) | (eq & cin)
//   - mode 10: hit = eq
//   - mode 11: hit = ~eq
//   - err forces hit = 0 and is passed through to out_err
//  Handshake: adv2 = ~s2_v | out_ready; adv1 = ~s1_v | adv2; in_ready = adv1.
//   - in_ready is combinational from out_ready; no other comb in->out path.
//   - Latency 2 cycles, input handshake to out_valid, when unstalled.
//   - Throughput 1 transaction per cycle.
//  Holding: while out_valid & ~out_ready, out_* are held stable.
//   - S1 is held when full and S2 is stalled.
//   - At most 2 transactions are in flight; no loss, no duplication, order preserved.
//  Counter: hit_cnt += 1 on out_valid & out_ready & out_hit.
//   - Saturates at 2^CNT_W-1 and never wraps.
//   - cnt_sat = (hit_cnt == all-ones), registered alongside hit_cnt.
//  cnt_clr: same-cycle clear plus increment gives hit_cnt = 1; clear alone gives 0.
//   - cnt_clr does not affect the pipeline.
// TESTING
//  1. Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, hit_cnt=0, in_ready=1 after rst.
//  2. Pipeline and tie-break (out_ready=1):
//     - in_data ch2=8'h40, in_sel=2, in_thr=8'h40, mode=00, cin=0 -> 2 cycles later out_hit=0, out_idx=2.
//     - Same with cin=1 -> out_hit=1.
//  3. Modes on ch0=8'h10, thr=8'h20:
//     - mode 01 -> hit=1
//     - mode 10 -> hit=0
//     - mode 11 -> hit=1
//     - Back-to-back stream gives one result per cycle in order.
//  4. Backpressure: 5 back-to-back inputs with out_ready=0 for 4 cycles:
//     - in_ready drops after 2 accepts; outputs stay stable.
//     - After release, all 5 results arrive in order with none lost.
//  5. Error select: NCH=3, in_sel=3 -> out_err=1, out_hit=0, hit_cnt unchanged.
//  6. Counter (CNT_W=2):
//     - 5 accepted hits -> hit_cnt=3, cnt_sat=1.
//     - cnt_clr together with an accepted hit -> hit_cnt=1, cnt_sat=0.
//     - Mid-flight rst -> no out_valid after reset.

Source files
------------

// File: rtl/chan_sel_cmp_pipe.sv
// chan_sel_cmp_pipe: NCH-way channel select, threshold compare, 2-stage elastic pipe and saturating hit counter.
module chan_sel_cmp_pipe #(
    parameter int NCH = 4,
    parameter int W = 8,
    parameter int CNT_W = 8,
    localparam int SW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH*W-1:0] in_data,
    input  logic [SW-1:0]    in_sel,
    input  logic [W-1:0]     in_thr,
    input  logic             in_cin,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [SW-1:0]    out_idx,
    output logic             out_err,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat,
    input  logic             cnt_clr
);
    logic             s1_v_q, s1_cin_q, s1_err_q;
    logic [W-1:0]     s1_val_q, s1_thr_q;
    logic [1:0]       s1_mode_q;
    logic [SW-1:0]    s1_idx_q;
    logic             s2_v_q, hit_q, err_q;
    logic [SW-1:0]    idx_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             adv1, adv2, take, sel_err, eq, hit_d, inc;
    logic [W-1:0]     sel_val;

    assign adv2     = ~s2_v_q | out_ready;
    assign adv1     = ~s1_v_q | adv2;
    assign in_ready = adv1;
    assign take     = in_valid & adv1;
    assign sel_err  = {1'b0, in_sel} >= (SW+1)'(NCH);

    // out-of-range selects match no channel, so the captured value is 0
    always_comb begin
        sel_val = '0;
        for (int c = 0; c < NCH; c++)
            if ({1'b0, in_sel} == (SW+1)'(c)) sel_val = in_data[c*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) s1_v_q <= 1'b0;
        else if (adv1) s1_v_q <= in_valid;
        if (take) begin
            s1_val_q  <= sel_val;
            s1_thr_q  <= in_thr;
            s1_cin_q  <= in_cin;
            s1_mode_q <= in_mode;
            s1_idx_q  <= in_sel;
            s1_err_q  <= sel_err;
        end
    end

    assign eq    = s1_val_q == s1_thr_q;
    assign hit_d = ~s1_err_q & (s1_mode_q == 2'd0 ? (s1_val_q > s1_thr_q) | (eq & s1_cin_q) :
                                s1_mode_q == 2'd1 ? (s1_val_q < s1_thr_q) | (eq & s1_cin_q) :
                                s1_mode_q == 2'd2 ? eq : ~eq);

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q <= 1'b0;
            hit_q  <= 1'b0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else if (adv2) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                hit_q <= hit_d;
                idx_q <= s1_idx_q;
                err_q <= s1_err_q;
            end
        end
    end

    assign inc   = s2_v_q & out_ready & hit_q;
    assign cnt_d = cnt_clr ? CNT_W'(inc) : cnt_q + CNT_W'(inc & ~sat_q);
    assign sat_d = &cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_hit   = hit_q;
    assign out_idx   = idx_q;
    assign out_err   = err_q;
    assign hit_cnt   = cnt_q;
    assign cnt_sat   = sat_q;
endmodule
